// File: rtl/l2_arb_pkg.sv
// Shared encodings and line-geometry defaults for the L2 port arbiter.
// Used by l2_arb_rr and l2_port_arbiter.
package l2_arb_pkg;

    localparam int unsigned LINE_W_DEF   = 512;
    localparam int unsigned OFFSET_W_DEF = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/l2_arb_rr.sv
// Two-way round-robin picker: on a tie the requester that did not own the
// port last time wins; a lone requester always wins.
module l2_arb_rr
    import l2_arb_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  owner_e last_owner,
    output logic   grant_valid,
    output owner_e owner
);

    always_comb begin
        grant_valid = i_req | d_req;
        owner       = OWN_I;
        if (i_req && d_req) begin
            owner = (last_owner == OWN_I) ? OWN_D : OWN_I;
        end else if (d_req) begin
            owner = OWN_D;
        end
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares the single L2 port between I-cache refills and D-cache refills/write-backs.
// Optional statistics counters are built only when L2_ARB_STATS_EN is defined.
module l2_port_arbiter
    import l2_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned LINE_W   = LINE_W_DEF,
    parameter int unsigned OFFSET_W = OFFSET_W_DEF,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_done,
    output logic [LINE_W-1:0] d_rdata,
    output logic              l2_req,
    output logic              l2_we,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic              l2_ack,
    input  logic [LINE_W-1:0] l2_rdata,
    output logic [CNT_W-1:0]  i_grants,
    output logic [CNT_W-1:0]  d_grants,
    output logic [CNT_W-1:0]  d_wbacks,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

    arb_state_e        state_q;
    owner_e            owner_q, last_owner_q;
    logic              l2_req_q, l2_we_q, i_done_q, d_done_q;
    logic [ADDR_W-1:0] l2_addr_q;
    logic [LINE_W-1:0] l2_wdata_q, i_rdata_q, d_rdata_q;

    logic   grant_valid;
    owner_e grant_owner;

    l2_arb_rr u_rr (
        .i_req       (i_req),
        .d_req       (d_req),
        .last_owner  (last_owner_q),
        .grant_valid (grant_valid),
        .owner       (grant_owner)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q      <= IDLE;
            owner_q      <= OWN_D;
            last_owner_q <= OWN_D;
            l2_req_q     <= 1'b0;
            l2_we_q      <= 1'b0;
            l2_addr_q    <= '0;
            l2_wdata_q   <= '0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            // NOTE: the wide line registers are reset too, because every output must read 0 after clear.
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        owner_q      <= grant_owner;
                        last_owner_q <= grant_owner;
                        l2_req_q     <= 1'b1;
                        state_q      <= ISSUE;
                        if (grant_owner == OWN_I) begin
                            l2_addr_q  <= i_addr & LINE_MASK;
                            l2_we_q    <= 1'b0;
                            l2_wdata_q <= '0;
                        end else begin
                            l2_addr_q  <= d_addr & LINE_MASK;
                            l2_we_q    <= d_we;
                            l2_wdata_q <= d_wdata;
                        end
                    end
                end
                ISSUE: begin
                    // l2_ack only has meaning here; strays in IDLE/DONE fall through.
                    if (l2_ack) begin
                        l2_req_q <= 1'b0;
                        state_q  <= DONE;
                        if (owner_q == OWN_I) begin
                            i_rdata_q <= l2_rdata;
                            i_done_q  <= 1'b1;
                        end else begin
                            if (!l2_we_q) d_rdata_q <= l2_rdata;
                            d_done_q <= 1'b1;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign l2_req   = l2_req_q;
    assign l2_we    = l2_we_q;
    assign l2_addr  = l2_addr_q;
    assign l2_wdata = l2_wdata_q;
    assign i_done   = i_done_q;
    assign d_done   = d_done_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;

`ifdef L2_ARB_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && !(&v)) ? v + CNT_W'(1) : v;
    endfunction

    logic             grant_i, grant_d, busy, stall;
    logic [CNT_W-1:0] i_grants_q, d_grants_q, d_wbacks_q, stall_q;
    logic [CNT_W-1:0] i_grants_d, d_grants_d, d_wbacks_d, stall_d;

    // A requester stalls when it is neither being granted nor holding the port.
    assign grant_i = (state_q == IDLE) && grant_valid && (grant_owner == OWN_I);
    assign grant_d = (state_q == IDLE) && grant_valid && (grant_owner == OWN_D);
    assign busy    = (state_q != IDLE);
    assign stall   = (i_req && !(grant_i || (busy && owner_q == OWN_I)))
                   | (d_req && !(grant_d || (busy && owner_q == OWN_D)));

    assign i_grants_d = sat_inc(i_grants_q, grant_i);
    assign d_grants_d = sat_inc(d_grants_q, grant_d);
    assign d_wbacks_d = sat_inc(d_wbacks_q, grant_d && d_we);
    assign stall_d    = sat_inc(stall_q, stall);

    always_ff @(posedge clk) begin
        if (clear) begin
            i_grants_q <= '0;
            d_grants_q <= '0;
            d_wbacks_q <= '0;
            stall_q    <= '0;
        end else begin
            i_grants_q <= i_grants_d;
            d_grants_q <= d_grants_d;
            d_wbacks_q <= d_wbacks_d;
            stall_q    <= stall_d;
        end
    end

    assign i_grants     = i_grants_q;
    assign d_grants     = d_grants_q;
    assign d_wbacks     = d_wbacks_q;
    assign stall_cycles = stall_q;
`else
    assign i_grants     = '0;
    assign d_grants     = '0;
    assign d_wbacks     = '0;
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Scoreboard bench for l2_port_arbiter: stimulus pushes expected L2 transactions and
// completions; a monitor compares them when the DUT presents l2_req or a done pulse.
`timescale 1ns/1ps
module tb_l2_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 512;
    localparam int CNT_W  = 32;

    localparam int M_NORMAL = 0;
    localparam int M_SILENT = 1;
    localparam int M_ALWAYS = 2;

    logic              clk = 1'b0;
    logic              clear;
    logic              i_req, d_req, d_we, l2_ack;
    logic [ADDR_W-1:0] i_addr, d_addr;
    logic [LINE_W-1:0] d_wdata, l2_rdata;
    logic              i_done, d_done, l2_req, l2_we;
    logic [LINE_W-1:0] i_rdata, d_rdata, l2_wdata;
    logic [ADDR_W-1:0] l2_addr;
    logic [CNT_W-1:0]  i_grants, d_grants, d_wbacks, stall_cycles;

    always #5 clk = ~clk;

    l2_port_arbiter dut (
        .clk          (clk),
        .clear        (clear),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_done       (i_done),
        .i_rdata      (i_rdata),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_done       (d_done),
        .d_rdata      (d_rdata),
        .l2_req       (l2_req),
        .l2_we        (l2_we),
        .l2_addr      (l2_addr),
        .l2_wdata     (l2_wdata),
        .l2_ack       (l2_ack),
        .l2_rdata     (l2_rdata),
        .i_grants     (i_grants),
        .d_grants     (d_grants),
        .d_wbacks     (d_wbacks),
        .stall_cycles (stall_cycles)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [LINE_W-1:0] wdata;
        logic              chk_wdata;
    } l2_exp_t;

    typedef struct packed {
        logic              own_d;
        logic [LINE_W-1:0] rdata;
    } done_exp_t;

    l2_exp_t           l2_q[$];
    done_exp_t         done_q[$];
    string             chk_name_q[$];
    logic [LINE_W-1:0] chk_act_q[$];
    logic [LINE_W-1:0] chk_exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    int l2_mode = M_NORMAL;
    int ack_delay = 2;
    int wait_cnt = 0;
    int cyc = 0;
    int req_cyc = 0;
    int rise_cyc = -100;
    int ack_cyc = -100;
    bit prev_l2_req = 1'b0;
    bit gap_chk_en = 1'b0;
    logic [LINE_W-1:0] exp_i_rdata = '0;
    logic [LINE_W-1:0] exp_d_rdata = '0;

    function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_W-1:0] a);
        return {16{a ^ 32'hC0DE_0000}};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    initial begin : monitor
        l2_exp_t   cur;
        done_exp_t de;
        bit        prev_req;
        int        mcyc;
        int        last_done;
        cur = '0;
        prev_req = 1'b0;
        mcyc = 0;
        last_done = -1;
        forever begin
            @(posedge clk);
            #1;
            mcyc++;
            while (chk_name_q.size() > 0)
                check(chk_name_q.pop_front(), chk_act_q.pop_front(), chk_exp_q.pop_front());
            if (l2_req === 1'b1 && !prev_req) begin
                check("l2_exp_avail", LINE_W'(l2_q.size() > 0), 1);
                if (l2_q.size() > 0) begin
                    cur = l2_q.pop_front();
                    check("l2_addr", LINE_W'(l2_addr), LINE_W'(cur.addr));
                    check("l2_we", LINE_W'(l2_we), LINE_W'(cur.we));
                    if (cur.chk_wdata) check("l2_wdata", l2_wdata, cur.wdata);
                end
            end else if (l2_req === 1'b1) begin
                check("l2_hold", LINE_W'({l2_addr, l2_we}), LINE_W'({cur.addr, cur.we}));
            end
            prev_req = (l2_req === 1'b1);
            if (!gap_chk_en) last_done = -1;
            if (i_done === 1'b1 || d_done === 1'b1) begin
                check("done_onehot", LINE_W'(i_done & d_done), 0);
                check("done_exp_avail", LINE_W'(done_q.size() > 0), 1);
                if (done_q.size() > 0) begin
                    de = done_q.pop_front();
                    check("done_owner", LINE_W'(d_done), LINE_W'(de.own_d));
                    check(de.own_d ? "d_rdata" : "i_rdata", de.own_d ? d_rdata : i_rdata, de.rdata);
                    if (gap_chk_en && last_done >= 0)
                        check("done_gap", LINE_W'(mcyc - last_done), 3);
                    last_done = mcyc;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic expect_val(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        chk_name_q.push_back(name);
        chk_act_q.push_back(act);
        chk_exp_q.push_back(exp);
    endtask

    task automatic push_l2(input logic [ADDR_W-1:0] a, input logic we, input logic [LINE_W-1:0] wd, input logic cw);
        l2_exp_t e;
        e.addr = a;
        e.we = we;
        e.wdata = wd;
        e.chk_wdata = cw;
        l2_q.push_back(e);
    endtask

    task automatic push_done(input logic own_d, input logic [LINE_W-1:0] rd);
        done_exp_t e;
        e.own_d = own_d;
        e.rdata = rd;
        done_q.push_back(e);
        if (own_d) exp_d_rdata = rd;
        else exp_i_rdata = rd;
    endtask

    // One cycle: wait for the falling edge, then play the L2 model.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (l2_req && !prev_l2_req) rise_cyc = cyc;
        prev_l2_req = l2_req;
        l2_rdata = line_of(l2_addr);
        case (l2_mode)
            M_ALWAYS: l2_ack = 1'b1;
            M_SILENT: begin
                l2_ack = 1'b0;
                wait_cnt = 0;
            end
            default: begin
                if (l2_req) begin
                    if (wait_cnt == ack_delay) begin
                        l2_ack = 1'b1;
                        ack_cyc = cyc;
                        wait_cnt = 0;
                    end else begin
                        l2_ack = 1'b0;
                        wait_cnt++;
                    end
                end else begin
                    l2_ack = 1'b0;
                    wait_cnt = 0;
                end
            end
        endcase
    endtask

    task automatic wait_done(input bit want_d, input string tag);
        for (int n = 0; n < 50; n++) begin
            tick();
            if (want_d ? d_done : i_done) return;
        end
        expect_val({tag, "_done_seen"}, LINE_W'(want_d ? d_done : i_done), 1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed tests ----------------
    initial begin : stimulus
        int n;
        clear = 1'b1;
        i_req = 1'b0;
        d_req = 1'b0;
        d_we = 1'b0;
        l2_ack = 1'b0;
        i_addr = '0;
        d_addr = '0;
        d_wdata = '0;
        l2_rdata = '0;
        repeat (3) tick();
        expect_val("rst_ctrl", LINE_W'({l2_req, l2_we, i_done, d_done}), 0);
        expect_val("rst_l2_addr", LINE_W'(l2_addr), 0);
        expect_val("rst_l2_wdata", l2_wdata, 0);
        expect_val("rst_i_rdata", i_rdata, 0);
        expect_val("rst_d_rdata", d_rdata, 0);
        expect_val("rst_stats", LINE_W'({i_grants, d_grants, d_wbacks, stall_cycles}), 0);
        clear = 1'b0;
        tick();

        // 1: single I refill, ack two cycles after l2_req
        ack_delay = 2;
        i_addr = 32'h0000_1234;
        i_req = 1'b1;
        req_cyc = cyc;
        rise_cyc = -100;
        push_l2(32'h0000_1200, 1'b0, '0, 1'b0);
        push_done(1'b0, line_of(32'h0000_1200));
        wait_done(1'b0, "t1");
        expect_val("t1_req_to_l2req", LINE_W'(rise_cyc - req_cyc), 1);
        expect_val("t1_ack_to_done", LINE_W'(cyc - ack_cyc), 1);
        i_req = 1'b0;
        repeat (2) tick();

        // 2a: simultaneous requests after clear -> I first, then D
        do_clear();
        tick();
        ack_delay = 1;
        i_addr = 32'h0000_2077;
        d_addr = 32'h0000_3001;
        d_we = 1'b0;
        d_wdata = '0;
        i_req = 1'b1;
        d_req = 1'b1;
        push_l2(32'h0000_2040, 1'b0, '0, 1'b0);
        push_done(1'b0, line_of(32'h0000_2040));
        push_l2(32'h0000_3000, 1'b0, '0, 1'b1);
        push_done(1'b1, line_of(32'h0000_3000));
        wait_done(1'b0, "t2a_i");
        i_req = 1'b0;
        wait_done(1'b1, "t2a_d");
        d_req = 1'b0;
        tick();

        // 3: D write-back, d_rdata keeps the previous refill line
        d_addr = 32'h8000_0040;
        d_we = 1'b1;
        d_wdata = {64{8'hA5}};
        d_req = 1'b1;
        push_l2(32'h8000_0040, 1'b1, {64{8'hA5}}, 1'b1);
        push_done(1'b1, exp_d_rdata);
        wait_done(1'b1, "t3");
        d_req = 1'b0;
        d_we = 1'b0;
        d_wdata = '0;
        repeat (2) tick();

        // 6: statistics after tests 2a and 3 (D waited T..DONE of I's transaction = 4 cycles)
`ifdef L2_ARB_STATS_EN
        expect_val("t6_i_grants", LINE_W'(i_grants), 1);
        expect_val("t6_d_grants", LINE_W'(d_grants), 2);
        expect_val("t6_d_wbacks", LINE_W'(d_wbacks), 1);
        expect_val("t6_stall_cycles", LINE_W'(stall_cycles), 4);
`else
        expect_val("t6_i_grants", LINE_W'(i_grants), 0);
        expect_val("t6_d_grants", LINE_W'(d_grants), 0);
        expect_val("t6_d_wbacks", LINE_W'(d_wbacks), 0);
        expect_val("t6_stall_cycles", LINE_W'(stall_cycles), 0);
`endif

        // 2b: both held again -> I wins (last D), then D wins the next tie, then I
        i_addr = 32'h0000_A0C0;
        d_addr = 32'h0000_B010;
        i_req = 1'b1;
        d_req = 1'b1;
        push_l2(32'h0000_A0C0, 1'b0, '0, 1'b0);
        push_done(1'b0, line_of(32'h0000_A0C0));
        push_l2(32'h0000_B000, 1'b0, '0, 1'b1);
        push_done(1'b1, line_of(32'h0000_B000));
        push_l2(32'h0000_C000, 1'b0, '0, 1'b0);
        push_done(1'b0, line_of(32'h0000_C000));
        wait_done(1'b0, "t2b_i1");
        i_addr = 32'h0000_C03F;
        wait_done(1'b1, "t2b_d");
        d_req = 1'b0;
        wait_done(1'b0, "t2b_i2");
        i_req = 1'b0;
        repeat (2) tick();

        // 4: clear while waiting for ack, then a stray ack
        l2_mode = M_SILENT;
        d_addr = 32'h0000_4000;
        d_req = 1'b1;
        push_l2(32'h0000_4000, 1'b0, '0, 1'b1);
        repeat (3) tick();
        clear = 1'b1;
        tick();
        expect_val("t4_l2_req_after_clear", LINE_W'(l2_req), 0);
        expect_val("t4_d_rdata_cleared", d_rdata, 0);
        clear = 1'b0;
        d_req = 1'b0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        l2_ack = 1'b1;
        repeat (4) tick();
        expect_val("t4_l2_req_after_stray_ack", LINE_W'(l2_req), 0);
        l2_mode = M_NORMAL;
        ack_delay = 0;
        i_addr = 32'h7FFF_FFFF;
        i_req = 1'b1;
        req_cyc = cyc;
        rise_cyc = -100;
        push_l2(32'h7FFF_FFC0, 1'b0, '0, 1'b0);
        push_done(1'b0, line_of(32'h7FFF_FFC0));
        wait_done(1'b0, "t4_i");
        expect_val("t4_req_to_l2req", LINE_W'(rise_cyc - req_cyc), 1);
        i_req = 1'b0;
        repeat (2) tick();

        // 5: ack stuck high, both requesting -> D,I,D,I,D,I one done every 3 cycles
        l2_mode = M_ALWAYS;
        gap_chk_en = 1'b1;
        i_addr = 32'h0000_5000;
        d_addr = 32'h0000_6000;
        d_we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push_l2(32'h0000_6000, 1'b0, '0, 1'b1);
            push_done(1'b1, line_of(32'h0000_6000));
            push_l2(32'h0000_5000, 1'b0, '0, 1'b0);
            push_done(1'b0, line_of(32'h0000_5000));
        end
        i_req = 1'b1;
        d_req = 1'b1;
        n = 0;
        for (int k = 0; k < 40 && n < 6; k++) begin
            tick();
            if (i_done || d_done) n++;
        end
        i_req = 1'b0;
        d_req = 1'b0;
        expect_val("t5_done_count", LINE_W'(n), 6);
        tick();
        gap_chk_en = 1'b0;
        l2_mode = M_NORMAL;
        repeat (3) tick();

        expect_val("l2_q_drained", LINE_W'(l2_q.size()), 0);
        expect_val("done_q_drained", LINE_W'(done_q.size()), 0);
        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
